// File: rtl/addsub_acc_stage.sv
// addsub_acc_stage: add/sub/load/clear accumulator feeding a 2-entry result FIFO.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_op/in_data accept
// operations (00 ADD, 01 SUB, 10 LOAD, 11 CLR); out_valid/out_ready/out_acc/
// out_flags present the queue head, flags = {C,V,Z,N}.
// Macro ADDSUB_SAT_EN: signed saturating ADD/SUB instead of wrap-around.
module addsub_acc_stage #(
  parameter int G = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [G-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [G-1:0] out_acc,
  output logic [3:0]   out_flags
);
  logic [G-1:0] r_acc, r_out_acc, r_tail_acc;
  logic [3:0]   r_out_flags, r_tail_flags;
  logic [1:0]   r_cnt;
  logic         w_sub, w_arith, w_c, w_v, w_push, w_pop;
  logic [G-1:0] w_b, w_sum, w_sat, w_res;
  logic [G:0]   w_full;
  logic [3:0]   w_flags;
  assign w_sub   = in_op == 2'b01;
  assign w_arith = ~in_op[1];
  assign w_b     = w_sub ? ~in_data : in_data;
  assign w_full  = {1'b0, r_acc} + {1'b0, w_b} + {{G{1'b0}}, w_sub};
  assign w_sum   = w_full[G-1:0];
  assign w_c     = w_arith & w_full[G];
  // Same-sign operands producing a different-sign sum == carry-in(MSB) ^ carry-out(MSB).
  assign w_v     = w_arith & (r_acc[G-1] == w_b[G-1]) & (w_sum[G-1] != r_acc[G-1]);
`ifdef ADDSUB_SAT_EN
  // Overflow direction follows the accumulator sign: positive clamps to max, negative to min.
  assign w_sat   = w_v ? {r_acc[G-1], {(G-1){~r_acc[G-1]}}} : w_sum;
`else
  assign w_sat   = w_sum;
`endif
  assign w_res   = w_arith ? w_sat : (in_op[0] ? '0 : in_data);
  assign w_flags = {w_c, w_v, w_res == '0, w_res[G-1]};
  assign in_ready  = r_cnt != 2'd2;
  assign out_valid = r_cnt != 2'd0;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_acc   = r_out_acc;
  assign out_flags = r_out_flags;
  // Head lives in the output register so it keeps the last popped value when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_acc    <= '0;
      r_out_flags  <= '0;
      r_tail_acc   <= '0;
      r_tail_flags <= '0;
    end else begin
      if (w_push) r_acc <= w_res;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) begin
        r_out_acc   <= w_res;
        r_out_flags <= w_flags;
      end else if (w_pop && r_cnt == 2'd2) begin
        r_out_acc   <= r_tail_acc;
        r_out_flags <= r_tail_flags;
      end
      if (w_push && r_cnt == 2'd1 && !w_pop) begin
        r_tail_acc   <= w_res;
        r_tail_flags <= w_flags;
      end
    end
  end
endmodule

// File: doc/addsub_acc_stage.md
ADDSUB_ACC_STAGE -- requirements
Module: addsub_acc_stage

Interface
REQ-001 Parameter: G, default 32, operand and accumulator width in bits (G >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request is valid.
REQ-005 Port: in_ready  output  1  stage can accept an operation.
REQ-006 Port: in_op  input  2  operation: 00 ADD, 01 SUB, 10 LOAD, 11 CLR.
REQ-007 Port: in_data  input  G  operand.
REQ-008 Port: out_valid  output  1  result at queue head is valid.
REQ-009 Port: out_ready  input  1  downstream accepts the result.
REQ-010 Port: out_acc  output  G  accumulator value after the operation.
REQ-011 Port: out_flags  output  4  {C,V,Z,N} for that result.

Function
REQ-012 An operation is accepted on a rising edge with in_valid=1 and in_ready=1; in_op and in_data are ignored otherwise.
REQ-013 On acceptance: ADD sets acc = acc + in_data; SUB sets acc = acc + ~in_data + 1; LOAD sets acc = in_data; CLR sets acc = 0.
REQ-014 ADD/SUB use a G-bit ripple-carry add/subtract datapath: C = carry-out of bit G-1 (for SUB, C=1 means no borrow); V = signed overflow (carry into MSB XOR carry out of MSB).
REQ-015 For LOAD and CLR: C=0, V=0.
REQ-016 Z = (resulting acc == 0); N = resulting acc[G-1]; both computed on the value written to acc.
REQ-017 Without saturation, arithmetic wraps modulo 2^G.
REQ-018 Every accepted operation pushes exactly one {acc, flags} entry into a 2-entry FIFO; out_acc/out_flags present the head entry.
REQ-019 Latency: the result appears at the queue head (out_valid=1) in the cycle after acceptance when the queue was empty.
REQ-020 A result is popped on a rising edge with out_valid=1 and out_ready=1.
REQ-021 in_ready = (FIFO occupancy < 2), driven from registered state only; no combinational path from out_ready to in_ready.
REQ-022 Full queue with a pop that cycle: in_ready stays 0 that cycle; acceptance resumes the next cycle.
REQ-023 Occupancy 1 with simultaneous push and pop: occupancy stays 1; the new entry becomes head; order is always FIFO.
REQ-024 out_acc/out_flags are held stable while out_valid=1 and out_ready=0.
REQ-025 With out_valid=0, out_acc/out_flags hold their last popped values (0 after reset).

Reset
REQ-026 rst_n low asynchronously clears acc, occupancy, out_valid, out_acc and out_flags to 0; queued results are discarded.
REQ-027 During and immediately after reset, in_ready=1 (occupancy 0).
REQ-028 A reset asserted mid-operation takes effect without waiting for a clock edge; the first operation after release sees acc=0.

Configuration
REQ-029 Macro ADDSUB_SAT_EN selects signed saturating accumulation.
REQ-030 With ADDSUB_SAT_EN defined: on ADD/SUB with V=1, acc is set to 0111..1 (positive overflow) or 1000..0 (negative overflow); V still reports 1; C reports the raw carry; Z/N reflect the saturated value.
REQ-031 With ADDSUB_SAT_EN undefined: wrap-around per REQ-017; no saturation logic is present.

Verification (G=8)
REQ-032 LOAD 0x7F, then ADD 0x01, out_ready=1 -> results 0x7F flags 0000, then 0x80 flags 0101; with ADDSUB_SAT_EN: 0x7F flags 0100.
REQ-033 LOAD 0x05, then SUB 0x05 -> 0x00 flags 1010; LOAD 0x01, then ADD 0xFF -> 0x00 flags 1010; CLR -> 0x00 flags 0010.
REQ-034 out_ready=0, in_valid=1 with three ops (LOAD 0x01, ADD 0x01, ADD 0x01) -> first two accepted, in_ready=0 on the third; raising out_ready drains 0x01, 0x02, then 0x03 is accepted and emitted; order preserved.
REQ-035 Continuous in_valid=1, out_ready=1, 10 ADD 0x01 after CLR -> one result per cycle, values 0x01..0x0A, in_ready never drops.
REQ-036 Two results queued, rst_n pulsed low between edges -> out_valid=0 immediately, queue empty; next ADD 0x03 yields 0x03 flags 0000.
